// File: rtl/decode_issue_scoreboard_pkg.sv
// Shared types and default sizing for the decode-to-execute issue scoreboard.
// Register ID FLAGS_REG_ID is the pseudo-register that tracks pending flags writes.
package scoreboard_pkg;

    localparam int NUM_REGS     = 32;
    localparam int REG_ID_W     = 6;
    localparam int MAX_INFLIGHT = 8;
    localparam int CNT_W        = 4;
    localparam int FLAGS_REG_ID = NUM_REGS;

    typedef enum logic [1:0] {
        SB_RUN,
        SB_DRAIN,
        SB_HALTED
    } sb_state_t;

    typedef struct packed {
        logic [REG_ID_W-1:0] src_a;
        logic [REG_ID_W-1:0] src_b;
        logic [REG_ID_W-1:0] dst;
        logic                src_a_en;
        logic                src_b_en;
        logic                dst_en;
        logic                uses_flags;
        logic                sets_flags;
        logic                is_halt;
    } sb_req_t;

endpackage

// File: rtl/decode_issue_scoreboard_if.sv
// Decode request, execute-bus issue handshake and writeback/retire feedback.
// master = decode/execute side, slave = scoreboard.
interface decode_issue_scoreboard_if #(
    parameter int REG_ID_W = scoreboard_pkg::REG_ID_W
) ();

    logic                dec_valid;
    logic                dec_ready;
    logic [REG_ID_W-1:0] dec_src_a;
    logic [REG_ID_W-1:0] dec_src_b;
    logic                dec_src_a_en;
    logic                dec_src_b_en;
    logic [REG_ID_W-1:0] dec_dst;
    logic                dec_dst_en;
    logic                dec_uses_flags;
    logic                dec_sets_flags;
    logic                dec_is_halt;
    logic                exec_ready;
    logic                issue_valid;
    logic                wb_valid;
    logic [REG_ID_W-1:0] wb_dst;
    logic                retire;

    modport master (
        output dec_valid, dec_src_a, dec_src_b, dec_src_a_en, dec_src_b_en,
               dec_dst, dec_dst_en, dec_uses_flags, dec_sets_flags, dec_is_halt,
               exec_ready, wb_valid, wb_dst, retire,
        input  dec_ready, issue_valid
    );

    modport slave (
        input  dec_valid, dec_src_a, dec_src_b, dec_src_a_en, dec_src_b_en,
               dec_dst, dec_dst_en, dec_uses_flags, dec_sets_flags, dec_is_halt,
               exec_ready, wb_valid, wb_dst, retire,
        output dec_ready, issue_valid
    );

endinterface

// File: rtl/decode_issue_scoreboard_inflight_counter.sv
// Saturating up/down count of issued-but-unretired ops; registered count, one-cycle update.
// A decrement at zero is dropped and flagged on underflow (combinational, same cycle).
module sb_inflight_counter #(
    parameter int CNT_W        = 4,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             underflow
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             dec_ok;

    always_comb begin
        dec_ok    = dec & (count_q != '0);
        underflow = dec & (count_q == '0);
        count_d   = count_q;
        case ({inc, dec_ok})
            2'b10: if (count_q != CNT_W'(MAX_INFLIGHT)) count_d = count_q + 1'b1;
            2'b01: count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/decode_issue_scoreboard.sv
// RAW/WAW issue scoreboard with in-flight bound and HALT drain; issue is combinational (0 latency),
// stalls decode on hazard, !exec_ready or full pipe. SCOREBOARD_WB_BYPASS_EN lets same-cycle writeback unblock.
module decode_issue_scoreboard #(
    parameter int NUM_REGS     = scoreboard_pkg::NUM_REGS,
    parameter int REG_ID_W     = scoreboard_pkg::REG_ID_W,
    parameter int MAX_INFLIGHT = scoreboard_pkg::MAX_INFLIGHT,
    parameter int CNT_W        = scoreboard_pkg::CNT_W
) (
    input  logic                      clk,
    input  logic                      reset,
    decode_issue_scoreboard_if.slave  bus,
    output logic [NUM_REGS:0]         busy_mask,
    output logic [CNT_W-1:0]          inflight,
    output logic                      halted,
    output logic                      err
);

    import scoreboard_pkg::*;

    sb_state_t          state_q, state_d;
    sb_req_t            req;
    logic [NUM_REGS:0]  busy_q, busy_d, busy_eff, set_mask, clr_mask;
    logic               hazard, bad_id, wb_err, underflow;
    logic               issue_norm, issue_halt;
    logic               err_q;

    function automatic logic id_busy(input logic [NUM_REGS:0] m, input logic [REG_ID_W-1:0] id);
        return (int'(id) <= NUM_REGS) ? m[id] : 1'b0;
    endfunction

    function automatic logic id_bad(input logic [REG_ID_W-1:0] id);
        return int'(id) > NUM_REGS;
    endfunction

    assign req = '{src_a: bus.dec_src_a, src_b: bus.dec_src_b, dst: bus.dec_dst,
                   src_a_en: bus.dec_src_a_en, src_b_en: bus.dec_src_b_en,
                   dst_en: bus.dec_dst_en, uses_flags: bus.dec_uses_flags,
                   sets_flags: bus.dec_sets_flags, is_halt: bus.dec_is_halt};

    always_comb begin
        clr_mask = '0;
        if (bus.wb_valid && !id_bad(bus.wb_dst)) clr_mask[bus.wb_dst] = 1'b1;
    end

`ifdef SCOREBOARD_WB_BYPASS_EN
    assign busy_eff = busy_q & ~clr_mask;
`else
    assign busy_eff = busy_q;
`endif

    assign hazard = (req.src_a_en & id_busy(busy_eff, req.src_a))
                  | (req.src_b_en & id_busy(busy_eff, req.src_b))
                  | (req.dst_en   & id_busy(busy_eff, req.dst))
                  | (busy_eff[NUM_REGS] & (req.uses_flags | req.sets_flags));

    assign bad_id = (req.src_a_en & id_bad(req.src_a))
                  | (req.src_b_en & id_bad(req.src_b))
                  | (req.dst_en   & id_bad(req.dst));

    always_comb begin
        state_d    = state_q;
        issue_norm = 1'b0;
        issue_halt = 1'b0;
        case (state_q)
            SB_RUN: begin
                if (bus.dec_valid) begin
                    if (req.is_halt) begin
                        if (inflight != '0) begin
                            state_d = SB_DRAIN;
                        end else if (bus.exec_ready) begin
                            issue_halt = 1'b1;
                            state_d    = SB_HALTED;
                        end
                    end else if (!hazard && bus.exec_ready && int'(inflight) < MAX_INFLIGHT) begin
                        issue_norm = 1'b1;
                    end
                end
            end
            SB_DRAIN: begin
                if (inflight == '0 && bus.exec_ready) begin
                    issue_halt = 1'b1;
                    state_d    = SB_HALTED;
                end
            end
            SB_HALTED: state_d = SB_HALTED;
            default:   state_d = SB_RUN;
        endcase
    end

    assign bus.issue_valid = issue_norm | issue_halt;
    assign bus.dec_ready   = issue_norm | issue_halt;

    // A new writer to X owns it even if X's previous writer retires this cycle.
    always_comb begin
        set_mask = '0;
        if (issue_norm) begin
            if (req.dst_en && !id_bad(req.dst)) set_mask[req.dst] = 1'b1;
            if (req.sets_flags) set_mask[NUM_REGS] = 1'b1;
        end
        busy_d = (busy_q & ~clr_mask) | set_mask;
    end

    assign wb_err = bus.wb_valid & ~id_busy(busy_q, bus.wb_dst);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SB_RUN;
            busy_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            err_q   <= err_q | wb_err | underflow | (issue_norm & bad_id);
        end
    end

    sb_inflight_counter #(
        .CNT_W        (CNT_W),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_inflight (
        .clk       (clk),
        .reset     (reset),
        .inc       (issue_norm),
        .dec       (bus.retire),
        .count     (inflight),
        .underflow (underflow)
    );

    assign busy_mask = busy_q;
    assign halted    = (state_q == SB_HALTED);
    assign err       = err_q;

endmodule

// File: tb/tb_decode_issue_scoreboard.sv
// Directed checks of the issue scoreboard: hazards, in-flight bound, HALT drain, errors, reset.
module tb_decode_issue_scoreboard;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [32:0] busy_mask;
    logic [3:0]  inflight;
    logic        halted;
    logic        err;
    int          n_checks = 0;
    int          n_fail = 0;

    decode_issue_scoreboard_if bus ();

    decode_issue_scoreboard dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .busy_mask (busy_mask),
        .inflight  (inflight),
        .halted    (halted),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.dec_valid      = 1'b0;
        bus.dec_src_a      = '0;
        bus.dec_src_b      = '0;
        bus.dec_src_a_en   = 1'b0;
        bus.dec_src_b_en   = 1'b0;
        bus.dec_dst        = '0;
        bus.dec_dst_en     = 1'b0;
        bus.dec_uses_flags = 1'b0;
        bus.dec_sets_flags = 1'b0;
        bus.dec_is_halt    = 1'b0;
        bus.exec_ready     = 1'b1;
        bus.wb_valid       = 1'b0;
        bus.wb_dst         = '0;
        bus.retire         = 1'b0;
    endtask

    task automatic set_op(input logic [5:0] a, input logic aen, input logic [5:0] b, input logic ben,
                          input logic [5:0] d, input logic den, input logic uf, input logic sf,
                          input logic h);
        bus.dec_valid      = 1'b1;
        bus.dec_src_a      = a;
        bus.dec_src_a_en   = aen;
        bus.dec_src_b      = b;
        bus.dec_src_b_en   = ben;
        bus.dec_dst        = d;
        bus.dec_dst_en     = den;
        bus.dec_uses_flags = uf;
        bus.dec_sets_flags = sf;
        bus.dec_is_halt    = h;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (busy_mask !== 33'h0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", busy_mask); end
        n_checks++; if (inflight !== 4'd0) begin n_fail++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_checks++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_issue: got %b want 0", bus.issue_valid); end
    endtask

    task automatic test_raw();
        do_reset();
        set_op(6'd1, 1'b1, 6'd2, 1'b1, 6'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++; if (bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL raw_add_issue: got %b want 1", bus.issue_valid); end
        tick();
        idle();
        n_checks++; if (busy_mask !== 33'h8) begin n_fail++; $display("FAIL raw_busy3: got %h want 8", busy_mask); end
        n_checks++; if (inflight !== 4'd1) begin n_fail++; $display("FAIL raw_inflight1: got %0d want 1", inflight); end
        set_op(6'd3, 1'b1, 6'd0, 1'b0, 6'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++; if (bus.dec_ready !== 1'b0) begin n_fail++; $display("FAIL raw_move_stall: got %b want 0", bus.dec_ready); end
        tick();
        n_checks++; if (bus.dec_ready !== 1'b0) begin n_fail++; $display("FAIL raw_move_stall2: got %b want 0", bus.dec_ready); end
        bus.wb_valid = 1'b1;
        bus.wb_dst   = 6'd3;
        #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
        n_checks++; if (bus.dec_ready !== 1'b1) begin n_fail++; $display("FAIL raw_bypass_issue: got %b want 1", bus.dec_ready); end
        tick();
        idle();
`else
        n_checks++; if (bus.dec_ready !== 1'b0) begin n_fail++; $display("FAIL raw_wb_cycle_stall: got %b want 0", bus.dec_ready); end
        tick();
        bus.wb_valid = 1'b0;
        #1;
        n_checks++; if (bus.dec_ready !== 1'b1) begin n_fail++; $display("FAIL raw_after_wb_issue: got %b want 1", bus.dec_ready); end
        tick();
        idle();
`endif
        n_checks++; if (busy_mask !== 33'h10) begin n_fail++; $display("FAIL raw_busy4: got %h want 10", busy_mask); end
        n_checks++; if (inflight !== 4'd2) begin n_fail++; $display("FAIL raw_inflight2: got %0d want 2", inflight); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL raw_err: got %b want 0", err); end
    endtask

    task automatic test_flags();
        do_reset();
        set_op(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        n_checks++; if (bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL flags_cmp_issue: got %b want 1", bus.issue_valid); end
        tick();
        n_checks++; if (busy_mask !== 33'h1_0000_0000) begin n_fail++; $display("FAIL flags_busy32: got %h want 100000000", busy_mask); end
        set_op(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        n_checks++; if (bus.dec_ready !== 1'b0) begin n_fail++; $display("FAIL flags_jmp_stall: got %b want 0", bus.dec_ready); end
        set_op(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        n_checks++; if (bus.dec_ready !== 1'b0) begin n_fail++; $display("FAIL flags_cmp_waw: got %b want 0", bus.dec_ready); end
        idle();
        bus.wb_valid = 1'b1;
        bus.wb_dst   = 6'd32;
        tick();
        idle();
        n_checks++; if (busy_mask !== 33'h0) begin n_fail++; $display("FAIL flags_cleared: got %h want 0", busy_mask); end
        set_op(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        n_checks++; if (bus.dec_ready !== 1'b1) begin n_fail++; $display("FAIL flags_jmp_release: got %b want 1", bus.dec_ready); end
        tick();
        idle();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL flags_err: got %b want 0", err); end
    endtask

    task automatic test_inflight_limit();
        do_reset();
        set_op(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            #1;
            n_checks++; if (bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL lim_issue%0d: got %b want 1", i, bus.issue_valid); end
            tick();
        end
        n_checks++; if (inflight !== 4'd7) begin n_fail++; $display("FAIL lim_inflight7: got %0d want 7", inflight); end
        bus.retire = 1'b1;
        tick();
        bus.retire = 1'b0;
        n_checks++; if (inflight !== 4'd7) begin n_fail++; $display("FAIL lim_issue_retire: got %0d want 7", inflight); end
        tick();
        n_checks++; if (inflight !== 4'd8) begin n_fail++; $display("FAIL lim_inflight8: got %0d want 8", inflight); end
        #1;
        n_checks++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL lim_ninth_held: got %b want 0", bus.issue_valid); end
        bus.retire = 1'b1;
        #1;
        n_checks++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL lim_held_on_retire: got %b want 0", bus.issue_valid); end
        tick();
        bus.retire = 1'b0;
        n_checks++; if (inflight !== 4'd7) begin n_fail++; $display("FAIL lim_after_retire: got %0d want 7", inflight); end
        #1;
        n_checks++; if (bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL lim_ninth_issue: got %b want 1", bus.issue_valid); end
        tick();
        idle();
        n_checks++; if (inflight !== 4'd8) begin n_fail++; $display("FAIL lim_back_to_8: got %0d want 8", inflight); end
    endtask

    task automatic test_halt();
        do_reset();
        set_op(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); tick(); tick();
        n_checks++; if (inflight !== 4'd3) begin n_fail++; $display("FAIL halt_inflight3: got %0d want 3", inflight); end
        set_op(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        n_checks++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL halt_no_issue: got %b want 0", bus.issue_valid); end
        tick();
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_drain_not_halted: got %b want 0", halted); end
        n_checks++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL halt_drain_no_issue: got %b want 0", bus.issue_valid); end
        bus.retire = 1'b1;
        tick(); tick(); tick();
        bus.retire = 1'b0;
        #1;
        n_checks++; if (inflight !== 4'd0) begin n_fail++; $display("FAIL halt_drained: got %0d want 0", inflight); end
        n_checks++; if (bus.issue_valid !== 1'b1 || bus.dec_ready !== 1'b1) begin n_fail++; $display("FAIL halt_issue: got %b/%b want 1/1", bus.issue_valid, bus.dec_ready); end
        tick();
        idle();
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_halted: got %b want 1", halted); end
        n_checks++; if (inflight !== 4'd0) begin n_fail++; $display("FAIL halt_not_counted: got %0d want 0", inflight); end
        set_op(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++; if (bus.dec_ready !== 1'b0 || bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL halt_blocks: got %b/%b want 0/0", bus.dec_ready, bus.issue_valid); end
        tick();
        idle();
    endtask

    task automatic test_err();
        do_reset();
        bus.wb_valid = 1'b1;
        bus.wb_dst   = 6'd5;
        tick();
        idle();
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_wb_not_busy: got %b want 1", err); end
        tick();
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end
        do_reset();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b want 0", err); end
        bus.retire = 1'b1;
        tick();
        bus.retire = 1'b0;
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_underflow: got %b want 1", err); end
        n_checks++; if (inflight !== 4'd0) begin n_fail++; $display("FAIL err_underflow_cnt: got %0d want 0", inflight); end
        do_reset();
        set_op(6'd0, 1'b0, 6'd0, 1'b0, 6'd40, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++; if (bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL err_oor_issue: got %b want 1", bus.issue_valid); end
        tick();
        idle();
        n_checks++; if (err !== 1'b1 || busy_mask !== 33'h0) begin n_fail++; $display("FAIL err_oor_dst: got err=%b busy=%h want 1/0", err, busy_mask); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_op(6'd0, 1'b0, 6'd0, 1'b0, 6'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_op(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_op(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        bus.wb_valid = 1'b1;
        bus.wb_dst   = 6'd9;
        tick();
        bus.wb_valid = 1'b0;
        n_checks++; if (busy_mask !== 33'h80 || err !== 1'b1 || inflight !== 4'd2) begin n_fail++; $display("FAIL mid_pre: got busy=%h err=%b cnt=%0d want 80/1/2", busy_mask, err, inflight); end
        #1;
        reset = 1'b1;
        #1;
        n_checks++; if (busy_mask !== 33'h0 || inflight !== 4'd0) begin n_fail++; $display("FAIL mid_async_clear: got busy=%h cnt=%0d want 0/0", busy_mask, inflight); end
        n_checks++; if (halted !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL mid_async_flags: got halted=%b err=%b want 0/0", halted, err); end
        #1;
        reset = 1'b0;
        set_op(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++; if (bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL mid_run_again: got %b want 1", bus.issue_valid); end
        tick();
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_raw();
        test_flags();
        test_inflight_limit();
        test_halt();
        test_err();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
